iter_alu: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle datapath ALU.
- Adds arithmetic shift right, iterative multiply (low/high, signed/unsigned) and iterative divide/remainder.
- Registered results and valid/ready handshakes on both sides.
- Sits in the execute stage; the stage stalls on in_ready/out_valid while a multiply or divide iterates.

---
 rtl/iter_alu.sv | 278 +++++++++++++++++++++++++++
 tb/tb_iter_alu.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/iter_alu.sv
// Multi-cycle execute-stage ALU: single-cycle logic/shift/compare ops plus iterative
// shift-add multiply and restoring divide, with valid/ready handshakes on both sides.
module iter_alu #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       aluop,
    input  logic [WIDTH-1:0] port_a,
    input  logic [WIDTH-1:0] port_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] port_out,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             div_zero
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    localparam logic [4:0] OP_SLL   = 5'd0;
    localparam logic [4:0] OP_SRL   = 5'd1;
    localparam logic [4:0] OP_SRA   = 5'd2;
    localparam logic [4:0] OP_ADD   = 5'd3;
    localparam logic [4:0] OP_SUB   = 5'd4;
    localparam logic [4:0] OP_AND   = 5'd5;
    localparam logic [4:0] OP_OR    = 5'd6;
    localparam logic [4:0] OP_XOR   = 5'd7;
    localparam logic [4:0] OP_NOR   = 5'd8;
    localparam logic [4:0] OP_SLT   = 5'd9;
    localparam logic [4:0] OP_SLTU  = 5'd10;
    localparam logic [4:0] OP_MUL   = 5'd11;
    localparam logic [4:0] OP_MULH  = 5'd12;
    localparam logic [4:0] OP_MULHU = 5'd13;
    localparam logic [4:0] OP_DIV   = 5'd14;
    localparam logic [4:0] OP_DIVU  = 5'd15;
    localparam logic [4:0] OP_REM   = 5'd16;
    localparam logic [4:0] OP_REMU  = 5'd17;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [4:0]           op_q, op_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mop_q, mop_d;
    logic                 fix_neg_q, fix_neg_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic                 ovf_q, ovf_d;
    logic                 zero_q, zero_d;
    logic                 negative_q, negative_d;
    logic                 div_zero_q, div_zero_d;

    // Single-cycle result straight from the operand pins in the accept cycle
    logic [WIDTH-1:0] sc_res;
    logic             sc_ovf;
    logic [WIDTH-1:0] sc_sum;
    logic [WIDTH-1:0] sc_diff;
    logic [SHW-1:0]   shamt;

    always_comb begin
        sc_res  = '0;
        sc_ovf  = 1'b0;
        sc_sum  = port_a + port_b;
        sc_diff = port_a - port_b;
        shamt   = port_a[SHW-1:0];
        case (aluop)
            OP_SLL:  sc_res = port_b << shamt;
            OP_SRL:  sc_res = port_b >> shamt;
            OP_SRA:  sc_res = $signed(port_b) >>> shamt;
            OP_ADD: begin
                sc_res = sc_sum;
                sc_ovf = (port_a[WIDTH-1] == port_b[WIDTH-1]) &&
                         (sc_sum[WIDTH-1] != port_a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = sc_diff;
                sc_ovf = (port_a[WIDTH-1] != port_b[WIDTH-1]) &&
                         (sc_diff[WIDTH-1] != port_a[WIDTH-1]);
            end
            OP_AND:  sc_res = port_a & port_b;
            OP_OR:   sc_res = port_a | port_b;
            OP_XOR:  sc_res = port_a ^ port_b;
            OP_NOR:  sc_res = ~(port_a | port_b);
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(port_a) < $signed(port_b))};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (port_a < port_b)};
            default: sc_res = '0;
        endcase
    end

    // Iterative ops work on magnitudes; fix_neg records whether the result gets negated
    logic             in_iter, in_mul, in_signed;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             fix_neg_init;

    always_comb begin
        in_iter   = (aluop >= OP_MUL) && (aluop <= OP_REMU);
        in_mul    = (aluop >= OP_MUL) && (aluop <= OP_MULHU);
        in_signed = (aluop == OP_MUL) || (aluop == OP_MULH) ||
                    (aluop == OP_DIV) || (aluop == OP_REM);
        a_neg     = in_signed && port_a[WIDTH-1];
        b_neg     = in_signed && port_b[WIDTH-1];
        a_mag     = a_neg ? (~port_a + 1'b1) : port_a;
        b_mag     = b_neg ? (~port_b + 1'b1) : port_b;
        if (aluop == OP_REM) begin
            fix_neg_init = a_neg;
        end else begin
            fix_neg_init = a_neg ^ b_neg;
        end
    end

    // One iteration: multiply keeps {partial product, multiplier}, divide keeps {remainder, quotient}
    logic               is_mul_q, is_div_q;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_sub;
    logic               div_ge;
    logic [2*WIDTH-1:0] acc_step;

    always_comb begin
        is_mul_q  = (op_q >= OP_MUL) && (op_q <= OP_MULHU);
        is_div_q  = (op_q >= OP_DIV) && (op_q <= OP_REMU);
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                    (acc_q[0] ? {1'b0, mop_q} : {(WIDTH+1){1'b0}});
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, mop_q};
        div_sub   = div_shift[WIDTH-1:0] - mop_q;
        if (is_mul_q) begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end else if (div_ge) begin
            acc_step = {div_sub, acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end

    // Sign fix-up and divide-by-zero override applied to the final iteration's value
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;
    logic               b_is_zero;
    logic [WIDTH-1:0]   fin_res;

    always_comb begin
        prod      = fix_neg_q ? (~acc_step + 1'b1) : acc_step;
        quo       = fix_neg_q ? (~acc_step[WIDTH-1:0] + 1'b1) : acc_step[WIDTH-1:0];
        rem       = fix_neg_q ? (~acc_step[2*WIDTH-1:WIDTH] + 1'b1) : acc_step[2*WIDTH-1:WIDTH];
        b_is_zero = (mop_q == '0);
        if (b_is_zero) begin
            quo = '1;
            rem = a_q;
        end
        case (op_q)
            OP_MUL:            fin_res = prod[WIDTH-1:0];
            OP_MULH, OP_MULHU: fin_res = prod[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:   fin_res = quo;
            default:           fin_res = rem;
        endcase
    end

    logic load_res;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mop_d      = mop_q;
        fix_neg_d  = fix_neg_q;
        res_d      = res_q;
        ovf_d      = ovf_q;
        zero_d     = zero_q;
        negative_d = negative_q;
        div_zero_d = div_zero_q;
        load_res   = 1'b0;
        in_ready   = (state_q == IDLE);
        out_valid  = (state_q == DONE);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d = aluop;
                    a_d  = port_a;
                    if (in_iter) begin
                        state_d   = EXEC;
                        cnt_d     = CW'(WIDTH);
                        acc_d     = {{WIDTH{1'b0}}, (in_mul ? port_b_mag_sel(b_mag, a_mag, 1'b1)
                                                            : port_b_mag_sel(b_mag, a_mag, 1'b0))};
                        mop_d     = in_mul ? a_mag : b_mag;
                        fix_neg_d = fix_neg_init;
                    end else begin
                        state_d    = DONE;
                        res_d      = sc_res;
                        ovf_d      = sc_ovf;
                        div_zero_d = 1'b0;
                        load_res   = 1'b1;
                    end
                end
            end
            EXEC: begin
                acc_d = acc_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d    = DONE;
                    res_d      = fin_res;
                    ovf_d      = 1'b0;
                    div_zero_d = is_div_q && b_is_zero;
                    load_res   = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_res) begin
            zero_d     = (res_d == '0);
            negative_d = res_d[WIDTH-1];
        end
    end

    // Multiplier starts in the low half for multiply, dividend for divide
    function automatic logic [WIDTH-1:0] port_b_mag_sel(input logic [WIDTH-1:0] bm,
                                                        input logic [WIDTH-1:0] am,
                                                        input logic             mul);
        return mul ? bm : am;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            op_q       <= '0;
            a_q        <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            mop_q      <= '0;
            fix_neg_q  <= 1'b0;
            res_q      <= '0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mop_q      <= mop_d;
            fix_neg_q  <= fix_neg_d;
            res_q      <= res_d;
            ovf_q      <= ovf_d;
            zero_q     <= zero_d;
            negative_q <= negative_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign port_out = res_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;
    assign negative = negative_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_iter_alu.sv
// Randomised and directed bench for iter_alu against an arithmetic reference model.
module tb_iter_alu;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   aluop;
    logic [W-1:0] port_a;
    logic [W-1:0] port_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] port_out;
    logic         overflow;
    logic         zero;
    logic         negative;
    logic         div_zero;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    iter_alu #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluop     (aluop),
        .port_a    (port_a),
        .port_b    (port_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .port_out  (port_out),
        .overflow  (overflow),
        .zero      (zero),
        .negative  (negative),
        .div_zero  (div_zero)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference results from 64-bit integer arithmetic
    function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ov, output logic dz);
        longint sa, sb, ua, ub, t;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'h0, a};
        ub = {32'h0, b};
        r  = '0;
        ov = 1'b0;
        dz = 1'b0;
        case (op)
            5'd0:  r = b << a[4:0];
            5'd1:  r = b >> a[4:0];
            5'd2:  r = $signed(b) >>> a[4:0];
            5'd3:  begin t = sa + sb; r = t[31:0]; ov = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
            5'd4:  begin t = sa - sb; r = t[31:0]; ov = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
            5'd5:  r = a & b;
            5'd6:  r = a | b;
            5'd7:  r = a ^ b;
            5'd8:  r = ~(a | b);
            5'd9:  r = (sa < sb) ? 32'd1 : 32'd0;
            5'd10: r = (ua < ub) ? 32'd1 : 32'd0;
            5'd11: begin t = sa * sb; r = t[31:0]; end
            5'd12: begin t = sa * sb; r = t[63:32]; end
            5'd13: begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
            5'd14: if (b == 0) begin r = '1; dz = 1'b1; end else begin t = sa / sb; r = t[31:0]; end
            5'd15: if (b == 0) begin r = '1; dz = 1'b1; end else r = a / b;
            5'd16: if (b == 0) begin r = a; dz = 1'b1; end else begin t = sa % sb; r = t[31:0]; end
            5'd17: if (b == 0) begin r = a; dz = 1'b1; end else r = a % b;
            default: r = '0;
        endcase
    endfunction

    task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input bit hold_valid, input bit scramble, input int stall,
                                 input string tag);
        logic [31:0] er;
        logic        eo, ed;
        int          lat, exp_lat;
        model(op, a, b, er, eo, ed);
        exp_lat = (op >= 5'd11 && op <= 5'd17) ? W + 1 : 1;
        @(negedge CLK);
        checkOutput({tag, "_in_ready"}, in_ready, 1'b1);
        aluop    = op;
        port_a   = a;
        port_b   = b;
        in_valid = 1'b1;
        @(posedge CLK);
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
            if (!hold_valid) in_valid = 1'b0;
            if (scramble) begin
                port_a = $urandom;
                port_b = $urandom;
                aluop  = 5'($urandom);
            end
            checkOutput({tag, "_busy"}, in_ready, 1'b0);
        end while (!out_valid && lat < 100);
        checkOutput({tag, "_latency"}, lat, exp_lat);
        checkOutput({tag, "_port_out"}, port_out, er);
        checkOutput({tag, "_overflow"}, overflow, eo);
        checkOutput({tag, "_zero"}, zero, (er == 0));
        checkOutput({tag, "_negative"}, negative, er[31]);
        checkOutput({tag, "_div_zero"}, div_zero, ed);
        for (int s = 0; s < stall; s++) begin
            @(negedge CLK);
            checkOutput({tag, "_hold_valid"}, out_valid, 1'b1);
            checkOutput({tag, "_hold_out"}, port_out, er);
            checkOutput({tag, "_hold_ovf"}, overflow, eo);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
        checkOutput({tag, "_released"}, out_valid, 1'b0);
    endtask

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 40));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        RST       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        aluop     = '0;
        port_a    = '0;
        port_b    = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checkOutput("rst_in_ready", in_ready, 1'b1);
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_port_out", port_out, 0);
        checkOutput("rst_flags", {overflow, zero, negative, div_zero}, 4'b0000);
        RST = 1'b0;

        applyStimulus(5'd3,  32'h7FFF_FFFF, 32'h1,          0, 0, 3, "add_ovf");
        applyStimulus(5'd2,  32'd4,         32'hF000_0000,  0, 0, 0, "sra");
        applyStimulus(5'd1,  32'd4,         32'hF000_0000,  0, 0, 0, "srl");
        applyStimulus(5'd0,  32'd33,        32'h1,          0, 0, 0, "sll");
        applyStimulus(5'd4,  32'h8000_0000, 32'h1,          0, 0, 0, "sub_ovf");
        applyStimulus(5'd9,  32'hFFFF_FFFF, 32'h1,          0, 0, 0, "slt");
        applyStimulus(5'd10, 32'hFFFF_FFFF, 32'h1,          0, 0, 0, "sltu");
        applyStimulus(5'd25, 32'h1234,      32'h5678,       0, 0, 0, "invalid");
        applyStimulus(5'd12, 32'hFFFF_FFFE, 32'd3,          0, 0, 0, "mulh");
        applyStimulus(5'd11, 32'hFFFF_FFFE, 32'd3,          0, 0, 2, "mul");
        applyStimulus(5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  0, 0, 0, "mulhu");
        applyStimulus(5'd14, 32'hFFFF_FFF9, 32'd2,          0, 0, 0, "div");
        applyStimulus(5'd16, 32'hFFFF_FFF9, 32'd2,          0, 0, 0, "rem");
        applyStimulus(5'd15, 32'd7,         32'd0,          0, 0, 0, "divu_zero");
        applyStimulus(5'd17, 32'd7,         32'd0,          0, 0, 0, "remu_zero");
        applyStimulus(5'd14, 32'h8000_0000, 32'hFFFF_FFFF,  0, 0, 0, "div_min");
        applyStimulus(5'd16, 32'h8000_0000, 32'hFFFF_FFFF,  0, 0, 0, "rem_min");
        applyStimulus(5'd14, 32'hFFFF_FFF9, 32'd0,          0, 0, 0, "div_zero_neg");
        applyStimulus(5'd11, 32'hFFFF_FFFE, 32'd3,          1, 1, 0, "mul_hold");

        // Reset in the middle of a multiply
        @(negedge CLK);
        aluop    = 5'd11;
        port_a   = 32'd1000;
        port_b   = 32'd77;
        in_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        in_valid = 1'b0;
        repeat (9) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        checkOutput("midrst_in_ready", in_ready, 1'b1);
        checkOutput("midrst_out_valid", out_valid, 1'b0);
        checkOutput("midrst_port_out", port_out, 0);
        checkOutput("midrst_flags", {overflow, zero, negative, div_zero}, 4'b0000);
        applyStimulus(5'd3, 32'd2, 32'd3, 0, 0, 0, "add_after_rst");

        for (int i = 0; i < 40; i++) begin
            logic [4:0] op;
            op = 5'($urandom_range(0, 20));
            applyStimulus(op, pickOperand(), pickOperand(), 0, 0, 0, $sformatf("rand%0d_op%0d", i, op));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
